// File: rtl/nano4k_flash_pkg.sv
// rtl/nano4k_flash_pkg.sv - flash command codes, FSM states and address width for the nano4k burst reader
package nano4k_flash_pkg;

  localparam int FLASH_ADDR_W = 22;

  localparam logic [7:0] FREAD = 8'h0B;
  localparam logic [7:0] READ  = 8'h03;
  localparam logic [7:0] PP    = 8'h02;
  localparam logic [7:0] RSTEN = 8'h66;
  localparam logic [7:0] RST   = 8'h99;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    STREAM = 3'd2,
    GAP    = 3'd3,
    DRAIN  = 3'd4
  } state_e;

endpackage

// File: rtl/nano4k_sync_fifo.sv
// rtl/nano4k_sync_fifo.sv - single-clock FIFO with free-slot count, empty and full flags
module nano4k_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   free,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign free     = CW'(DEPTH) - count_q;
  assign pop_data = mem_q[rd_ptr_q];
  // a pop frees the head slot in the same cycle, so push-on-full is legal alongside a pop
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);

  // pointer and occupancy update; flush wins over any concurrent push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // pointer and count registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage array, written at the tail
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/nano4k_flash_burst_reader.sv
// rtl/nano4k_flash_burst_reader.sv - FREAD burst sequencer with FIFO-paced segments; FLASH_RD_TIMEOUT_EN adds byte timeout
module nano4k_flash_burst_reader
  import nano4k_flash_pkg::*;
#(
  parameter int LEN_W        = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int PAUSE_MARGIN = 2,
  parameter int CS_GAP       = 4
`ifdef FLASH_RD_TIMEOUT_EN
  , parameter int TIMEOUT    = 4096
`endif
) (
  input  logic                    interfaceClk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [FLASH_ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]        req_len,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    fEnable_n,
  output logic [7:0]              fCommand,
  output logic [FLASH_ADDR_W-1:0] fAddress,
  input  logic [7:0]              fData_RD,
  input  logic                    RdDataValid
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = $clog2(CS_GAP + 1);

  state_e                  state_q, state_d;
  logic [FLASH_ADDR_W-1:0] addr_q, addr_d;
  logic [FLASH_ADDR_W-1:0] seg_addr_q, seg_addr_d;
  logic [LEN_W-1:0]        rem_q, rem_d;
  logic [GW-1:0]           gap_q, gap_d;
  logic [2:0]              rdv_q, rdv_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    byte_edge, accept, seg_enable, pause;
  logic                    fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_full;
  logic [CW-1:0]           fifo_free;
`ifdef FLASH_RD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]           to_q, to_d;
`endif

  assign req_ready = reset_n & (state_q == IDLE) & ~done_q;
  assign accept    = req_valid & req_ready;
  assign busy      = (state_q != IDLE) | done_q;
  assign done      = done_q;
  assign err       = err_q;
  assign fCommand  = FREAD;
  assign fAddress  = seg_addr_q;
  // reset forces the chip select off in the same cycle it is asserted
  assign fEnable_n = ~(reset_n & seg_enable);
  assign out_valid = ~fifo_empty;
  assign fifo_pop  = out_ready & ~fifo_empty;
  // rdv_q[0..1] synchronize the MCLK-domain flag, rdv_q[2] is the edge-detect history
  assign rdv_d     = {rdv_q[1:0], RdDataValid};
  assign byte_edge = rdv_q[1] & ~rdv_q[2];
  assign fifo_push = byte_edge & (state_q == STREAM);
  assign pause     = fifo_full | (fifo_free <= CW'(PAUSE_MARGIN));

  // next-state, counters and chip-select decision
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    gap_d      = gap_q;
    done_d     = 1'b0;
    err_d      = err_q;
    seg_enable = 1'b0;
    fifo_flush = 1'b0;
`ifdef FLASH_RD_TIMEOUT_EN
    to_d       = to_q;
`endif
    if (fifo_push) begin
      addr_d = addr_q + 1'b1;
      rem_d  = rem_q - 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = req_addr;
          rem_d  = req_len;
          err_d  = 1'b0;
          if (req_len == '0) done_d = 1'b1;
          else               state_d = START;
        end
      end
      START: begin
        seg_enable = 1'b1;
        state_d    = STREAM;
`ifdef FLASH_RD_TIMEOUT_EN
        to_d       = '0;
`endif
      end
      STREAM: begin
        // the byte landing in the pause cycle is still stored; the margin leaves room for it
        if (rem_d == '0) begin
          state_d = DRAIN;
        end else if (pause) begin
          state_d = GAP;
          gap_d   = '0;
        end else begin
          seg_enable = 1'b1;
        end
`ifdef FLASH_RD_TIMEOUT_EN
        to_d = fifo_push ? '0 : to_q + 1'b1;
        if (!fifo_push && to_q == TW'(TIMEOUT - 1)) begin
          seg_enable = 1'b0;
          fifo_flush = 1'b1;
          err_d      = 1'b1;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
`endif
      end
      GAP: begin
        if (gap_q != GW'(CS_GAP)) gap_d = gap_q + 1'b1;
        if (gap_q >= GW'(CS_GAP - 1) && !pause) state_d = START;
      end
      DRAIN: begin
        if (fifo_empty) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // each new segment restarts at the first byte not yet stored
    seg_addr_d = (state_d == START) ? addr_d : seg_addr_q;
  end

  // state and datapath registers
  always_ff @(posedge interfaceClk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      seg_addr_q <= '0;
      rem_q      <= '0;
      gap_q      <= '0;
      rdv_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      seg_addr_q <= seg_addr_d;
      rem_q      <= rem_d;
      gap_q      <= gap_d;
      rdv_q      <= rdv_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

`ifdef FLASH_RD_TIMEOUT_EN
  // idle-byte counter for the stall abort
  always_ff @(posedge interfaceClk) begin
    if (!reset_n) to_q <= '0;
    else          to_q <= to_d;
  end
`endif

  nano4k_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (interfaceClk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (fData_RD),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .pop_data  (out_data),
    .free      (fifo_free),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_nano4k_flash_burst_reader.sv
// tb/tb_nano4k_flash_burst_reader.sv - directed bench with flash byte model and stream collector
module tb_nano4k_flash_burst_reader;

  localparam int GAP_MIN = 4;

  logic        clk = 1'b0;
  logic        reset_n, req_valid, req_ready, out_valid, out_ready;
  logic        busy, done, err, fEnable_n, RdDataValid, stop_model;
  logic [21:0] req_addr, fAddress;
  logic [15:0] req_len;
  logic [7:0]  out_data, fCommand, fData_RD;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0]  rx[$];
  logic [21:0] seg_addrs[$];
  int          falls, min_gap, high_run;
  logic        seen_low, prev_fen, ovf;
  logic        m_active;
  int          m_phase;
  logic [21:0] m_addr;

  always #5 clk = ~clk;

  nano4k_flash_burst_reader u_dut (
    .interfaceClk (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .fEnable_n    (fEnable_n),
    .fCommand     (fCommand),
    .fAddress     (fAddress),
    .fData_RD     (fData_RD),
    .RdDataValid  (RdDataValid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_trace();
    rx.delete();
    seg_addrs.delete();
    falls    = 0;
    min_gap  = 1000;
    high_run = 0;
    seen_low = 1'b0;
  endtask

  task automatic do_req(input logic [21:0] a, input logic [15:0] l);
    int n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_addr  = a;
    req_len   = l;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] first, input int cnt);
    logic [7:0] exp_b;
    logic [7:0] obs_b;
    check({tag, "_count"}, rx.size(), cnt);
    for (int i = 0; i < cnt; i++) begin
      exp_b = first + 8'(i);
      obs_b = (i < rx.size()) ? rx[i] : 8'hxx;
      check({tag, "_byte"}, {24'd0, obs_b}, {24'd0, exp_b});
    end
  endtask

  // flash model: byte value is the low address byte, one byte every six cycles while enabled
  initial begin
    RdDataValid = 1'b0;
    fData_RD    = 8'h00;
    m_active    = 1'b0;
    m_phase     = 0;
    m_addr      = '0;
    forever begin
      @(negedge clk);
      if (fEnable_n || stop_model) begin
        RdDataValid = 1'b0;
        m_active    = 1'b0;
        m_phase     = 0;
      end else begin
        if (!m_active) begin
          m_active = 1'b1;
          m_addr   = fAddress;
          m_phase  = 0;
        end
        case (m_phase)
          1: begin fData_RD = m_addr[7:0]; RdDataValid = 1'b1; end
          3: RdDataValid = 1'b0;
          5: m_addr = m_addr + 22'd1;
          default: ;
        endcase
        m_phase = (m_phase == 5) ? 0 : m_phase + 1;
      end
    end
  end

  // collector: consumed bytes, segment starts, chip-select high time, overflow watch
  initial begin
    prev_fen = 1'b1;
    ovf      = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) rx.push_back(out_data);
      if (fEnable_n) high_run++;
      if (prev_fen && !fEnable_n) begin
        falls++;
        seg_addrs.push_back(fAddress);
        if (seen_low && high_run < min_gap) min_gap = high_run;
        seen_low = 1'b1;
        high_run = 0;
      end
      prev_fen = fEnable_n;
      if (u_dut.u_fifo.push && u_dut.u_fifo.full && !u_dut.u_fifo.pop) ovf = 1'b1;
    end
  end

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_len    = '0;
    out_ready  = 1'b0;
    stop_model = 1'b0;
    clear_trace();
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_done",      {31'd0, done},      32'd0);
    check("rst_err",       {31'd0, err},       32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_fen",       {31'd0, fEnable_n}, 32'd1);
    check("rst_faddr",     {10'd0, fAddress},  32'd0);
    check("fcommand",      {24'd0, fCommand},  32'h0B);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);

    // 1: plain burst, consumer always ready
    clear_trace();
    out_ready = 1'b1;
    do_req(22'h000100, 16'd16);
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_done(2000);
    @(posedge clk); #1;
    check("t1_done_1cyc", {31'd0, done}, 32'd0);
    check("t1_busy_drop", {31'd0, busy}, 32'd0);
    check_bytes("t1", 8'h00, 16);
    check("t1_segments", falls, 1);

    // 2: consumer stalled, forces a pause and resume
    clear_trace();
    out_ready = 1'b0;
    do_req(22'h000100, 16'd16);
    repeat (200) @(posedge clk);
    #1;
    check("t2_paused_fen", {31'd0, fEnable_n}, 32'd1);
    check("t2_one_seg",    falls, 1);
    check("t2_out_valid",  {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    wait_done(2000);
    check_bytes("t2", 8'h00, 16);
    check("t2_segments", falls, 2);
    check("t2_resume_addr", (seg_addrs.size() > 1) ? {10'd0, seg_addrs[1]} : 32'hFFFFFFFF, 32'h000106);
    check("t2_gap_min", {31'd0, (min_gap >= GAP_MIN)}, 32'd1);

    // 3: address wrap at the top of the 22-bit space
    clear_trace();
    do_req(22'h3FFFFE, 16'd4);
    wait_done(2000);
    check_bytes("t3", 8'hFE, 4);
    check("t3_seg_addr", (seg_addrs.size() > 0) ? {10'd0, seg_addrs[0]} : 32'hFFFFFFFF, 32'h3FFFFE);

    // 4: zero-length request
    @(posedge clk); #1;
    clear_trace();
    do_req(22'h012345, 16'd0);
    check("t4_done", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    check("t4_done_1cyc", {31'd0, done}, 32'd0);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_no_seg", falls, 0);

    // 5: reset in the middle of a segment
    clear_trace();
    out_ready = 1'b0;
    do_req(22'h000200, 16'd16);
    begin
      int n = 0;
      while (out_valid !== 1'b1 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("t5_streaming", {31'd0, fEnable_n}, 32'd0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("t5_fen",       {31'd0, fEnable_n}, 32'd1);
    check("t5_out_valid", {31'd0, out_valid}, 32'd0);
    check("t5_done",      {31'd0, done},      32'd0);
    check("t5_busy",      {31'd0, busy},      32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    clear_trace();
    out_ready = 1'b1;
    do_req(22'h0003A0, 16'd4);
    wait_done(2000);
    check_bytes("t5", 8'hA0, 4);

`ifdef FLASH_RD_TIMEOUT_EN
    // 6: flash stops answering
    @(posedge clk); #1;
    clear_trace();
    stop_model = 1'b1;
    do_req(22'h000400, 16'd4);
    wait_done(5000);
    check("t6_err",       {31'd0, err},       32'd1);
    check("t6_out_valid", {31'd0, out_valid}, 32'd0);
    stop_model = 1'b0;
    @(posedge clk); #1;
    do_req(22'h000400, 16'd2);
    check("t6_err_clear", {31'd0, err}, 32'd0);
    wait_done(2000);
`else
    check("err_tied", {31'd0, err}, 32'd0);
`endif

    check("no_overflow", {31'd0, ovf}, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
